seven_seg_scan_ctrl: RTL and testbench

Time-multiplexing controller for the board's multi-digit seven-segment display. It holds a double-buffered display value and scans the digits one slot at a time from an internal prescaler, inserting an anti-ghosting blank at the start of each slot. New values are committed only at frame boundaries, so a displayed frame never mixes old and new digits. It sits between the application logic and the display pins, replacing ad-hoc divided-clock scanning with a single-clock, enable-based sequencer.

---
 rtl/seven_seg_pkg.sv | 25 ++
 rtl/hex_to_seg.sv | 16 +
 rtl/seven_seg_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan controller.
// Contents:
//   DefaultDigits - default number of scanned digits
//   SegBlank      - active-low "all segments off" pattern
//   HexSegTable   - hex digit to {g,f,e,d,c,b,a} active-low segment patterns
//   phase_e       - phase of the current digit slot (blank or show)
package seven_seg_pkg;

    localparam int unsigned DefaultDigits = 4;

    localparam logic [6:0] SegBlank = 7'h7F;

    localparam logic [6:0] HexSegTable [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        PhBlank,
        PhShow
    } phase_e;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex digit to seven-segment decoder.
// Ports:
//   hex - 4-bit hex digit
//   seg - segment drives {g,f,e,d,c,b,a}, active-low
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = HexSegTable[hex];
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexing scan controller for a multi-digit seven-segment display.
// Holds a staging buffer written by the application and a shadow buffer that
// is displayed; staging is copied to shadow only at the frame boundary so a
// frame never mixes old and new digits. Each digit slot starts with a short
// all-anodes-off window to suppress ghosting.
// Ports:
//   cin     - clock
//   rst     - synchronous active-high reset
//   load    - stage value/dp/en_mask
//   value   - hex digits, digit i at value[4i+3:4i], digit 0 rightmost
//   dp      - decimal-point request per digit, active-high
//   en_mask - digit enable, active-high
//   ack     - one-cycle pulse when staged data is committed to display
//   frame   - one-cycle pulse at the start of every frame
//   an      - anode drives, active-low
//   seg     - segment drives {g,f,e,d,c,b,a}, active-low
//   dp_n    - decimal-point drive, active-low
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGITS    = DefaultDigits,
    parameter int unsigned TICK_DIV  = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                  cin,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     en_mask,
    output logic                  ack,
    output logic                  frame,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp_n
);

    localparam int unsigned CntW  = $clog2(TICK_DIV);
    localparam int unsigned SlotW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CntW-1:0]  CntMax  = CntW'(TICK_DIV - 1);
    localparam logic [SlotW-1:0] SlotMax = SlotW'(DIGITS - 1);

    // Sequencer state
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic             boundary;
    logic             commit;

    // Staging and shadow buffers
    logic [4*DIGITS-1:0] stg_val_q, stg_val_d;
    logic [DIGITS-1:0]   stg_dp_q, stg_dp_d;
    logic [DIGITS-1:0]   stg_en_q, stg_en_d;
    logic                pending_q, pending_d;
    logic [4*DIGITS-1:0] shd_val_q, shd_val_d;
    logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
    logic [DIGITS-1:0]   shd_en_q, shd_en_d;

    // Output registers
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_n_q, dp_n_d;
    logic              ack_q, ack_d;
    logic              frame_q, frame_d;

    // Output decode inputs
    phase_e            phase_d;
    logic [3:0]        digit_sel;
    logic              en_sel;
    logic              dp_sel;
    logic [6:0]        seg_dec;
    logic [DIGITS-1:0] an_onehot;

    // Prescaler and slot counter
    always_comb begin
        boundary = (slot_q == SlotMax) && (cnt_q == CntMax);
        commit   = boundary && pending_q;
        cnt_d    = cnt_q + CntW'(1);
        slot_d   = slot_q;
        if (cnt_q == CntMax) begin
            cnt_d = '0;
            if (slot_q == SlotMax) begin
                slot_d = '0;
            end else begin
                slot_d = slot_q + SlotW'(1);
            end
        end
    end

    // Staging/shadow update. A load in the boundary cycle still lets the
    // previously staged data commit; the new data stays pending.
    always_comb begin
        stg_val_d = stg_val_q;
        stg_dp_d  = stg_dp_q;
        stg_en_d  = stg_en_q;
        pending_d = pending_q;
        shd_val_d = shd_val_q;
        shd_dp_d  = shd_dp_q;
        shd_en_d  = shd_en_q;
        if (commit) begin
            shd_val_d = stg_val_q;
            shd_dp_d  = stg_dp_q;
            shd_en_d  = stg_en_q;
            pending_d = 1'b0;
        end
        if (load) begin
            stg_val_d = value;
            stg_dp_d  = dp;
            stg_en_d  = en_mask;
            pending_d = 1'b1;
        end
    end

    // Outputs are decoded from next-state so the registered drives line up
    // with the counter/shadow state of the cycle in which they are visible.
    always_comb begin
        phase_d   = (32'(cnt_d) < BLANK_CYC) ? PhBlank : PhShow;
        digit_sel = shd_val_d[4*slot_d +: 4];
        en_sel    = shd_en_d[slot_d];
        dp_sel    = shd_dp_d[slot_d];
        an_onehot = DIGITS'(1) << slot_d;
    end

    hex_to_seg u_hex_to_seg (
        .hex (digit_sel),
        .seg (seg_dec)
    );

    always_comb begin
        an_d    = '1;
        seg_d   = SegBlank;
        dp_n_d  = 1'b1;
        ack_d   = commit;
        frame_d = boundary;
        if ((phase_d == PhShow) && en_sel) begin
            an_d   = ~an_onehot;
            seg_d  = seg_dec;
            dp_n_d = ~dp_sel;
        end
    end

    always_ff @(posedge cin) begin
        if (rst) begin
            cnt_q     <= '0;
            slot_q    <= '0;
            stg_val_q <= '0;
            stg_dp_q  <= '0;
            stg_en_q  <= '0;
            pending_q <= 1'b0;
            shd_val_q <= '0;
            shd_dp_q  <= '0;
            shd_en_q  <= '0;
            an_q      <= '1;
            seg_q     <= SegBlank;
            dp_n_q    <= 1'b1;
            ack_q     <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            stg_val_q <= stg_val_d;
            stg_dp_q  <= stg_dp_d;
            stg_en_q  <= stg_en_d;
            pending_q <= pending_d;
            shd_val_q <= shd_val_d;
            shd_dp_q  <= shd_dp_d;
            shd_en_q  <= shd_en_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_n_q    <= dp_n_d;
            ack_q     <= ack_d;
            frame_q   <= frame_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dp_n  = dp_n_q;
    assign ack   = ack_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed self-checking bench for seven_seg_scan_ctrl with DIGITS=4,
// TICK_DIV=8, BLANK_CYC=2 (32-cycle frame, 2 blank + 6 show cycles per slot).
module tb_seven_seg_scan_ctrl;

    logic        cin = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en_mask;
    logic        ack;
    logic        frame;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] seg_tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seven_seg_scan_ctrl #(
        .DIGITS    (4),
        .TICK_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .cin     (cin),
        .rst     (rst),
        .load    (load),
        .value   (value),
        .dp      (dp),
        .en_mask (en_mask),
        .ack     (ack),
        .frame   (frame),
        .an      (an),
        .seg     (seg),
        .dp_n    (dp_n)
    );

    always #5 cin = ~cin;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge cin);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps until frame pulses; checks step count, and that the display stayed
    // dark with no ack meanwhile.
    task automatic wait_frame(input int exp_steps, input string tag);
        int  n = 0;
        logic lit = 1'b0;
        logic acked = 1'b0;
        while (frame !== 1'b1 && n < 80) begin
            step();
            n++;
            if (an !== 4'hF) lit = 1'b1;
            if (ack !== 1'b0) acked = 1'b1;
        end
        chk({tag, " frame steps"}, n, exp_steps);
        chk({tag, " dark"}, lit, 1'b0);
        chk({tag, " no ack"}, acked, 1'b0);
    endtask

    task automatic wait_ack(input int exp_steps, input string tag);
        int n = 0;
        while (ack !== 1'b1 && n < 80) begin
            step();
            n++;
        end
        chk({tag, " ack steps"}, n, exp_steps);
        chk({tag, " frame with ack"}, frame, 1'b1);
    endtask

    // Called at slot 0 / cnt 0; checks one whole frame and ends at the next
    // frame start.
    task automatic check_frame(input logic [15:0] v, input logic [3:0] en,
                               input logic [3:0] d, input string tag);
        for (int p = 0; p < 32; p++) begin
            int         s;
            logic       blank;
            logic [3:0] one;
            logic [3:0] e_an;
            logic [6:0] e_seg;
            logic       e_dp;
            s     = p / 8;
            blank = ((p % 8) < 2) || !en[s];
            one   = 4'b0001 << s;
            e_an  = blank ? 4'hF : ~one;
            e_seg = blank ? 7'h7F : seg_tbl[v[4*s +: 4]];
            e_dp  = blank ? 1'b1 : ~d[s];
            chk($sformatf("%s an p%0d", tag, p), an, e_an);
            chk($sformatf("%s seg p%0d", tag, p), seg, e_seg);
            chk($sformatf("%s dp_n p%0d", tag, p), dp_n, e_dp);
            if (p > 0) begin
                chk($sformatf("%s ack p%0d", tag, p), ack, 1'b0);
                chk($sformatf("%s frame p%0d", tag, p), frame, 1'b0);
            end
            step();
        end
    endtask

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        value   = '0;
        dp      = '0;
        en_mask = '0;

        // Reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst an", an, 4'hF);
            chk("rst seg", seg, 7'h7F);
            chk("rst dp_n", dp_n, 1'b1);
            chk("rst ack", ack, 1'b0);
            chk("rst frame", frame, 1'b0);
        end
        rst = 1'b0;
        wait_frame(32, "first");
        chk("first frame ack", ack, 1'b0);
        chk("first frame an", an, 4'hF);

        // Basic load 1234
        value = 16'h1234; en_mask = 4'hF; dp = 4'h0; load = 1'b1;
        step();
        load = 1'b0;
        wait_ack(31, "basic");
        check_frame(16'h1234, 4'hF, 4'h0, "basic");
        chk("basic no recommit", ack, 1'b0);
        chk("basic frame", frame, 1'b1);

        // Overwrite within one frame
        value = 16'hAAAA; load = 1'b1;
        step();
        load = 1'b0;
        repeat (4) step();
        value = 16'h5555; load = 1'b1;
        step();
        load = 1'b0;
        wait_ack(26, "overwrite");
        check_frame(16'h5555, 4'hF, 4'h0, "overwrite");
        chk("overwrite single ack", ack, 1'b0);

        // Load in the boundary cycle while data is pending
        value = 16'h7777; load = 1'b1;
        step();
        load = 1'b0;
        repeat (30) step();
        value = 16'h89AB; load = 1'b1;
        step();
        load = 1'b0;
        chk("bnd ack1", ack, 1'b1);
        chk("bnd frame1", frame, 1'b1);
        check_frame(16'h7777, 4'hF, 4'h0, "bnd old");
        chk("bnd ack2", ack, 1'b1);
        check_frame(16'h89AB, 4'hF, 4'h0, "bnd new");
        chk("bnd no ack3", ack, 1'b0);

        // Mask and decimal point
        value = 16'hC0DE; en_mask = 4'b0101; dp = 4'b0001; load = 1'b1;
        step();
        load = 1'b0;
        wait_ack(31, "mask");
        check_frame(16'hC0DE, 4'b0101, 4'b0001, "mask");

        // Mid-frame reset with a load pending
        value = 16'h9999; en_mask = 4'hF; dp = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        repeat (17) step();
        chk("pre-rst an", an, 4'b1011);
        chk("pre-rst seg", seg, 7'h40);
        rst = 1'b1;
        step();
        chk("midrst an", an, 4'hF);
        chk("midrst seg", seg, 7'h7F);
        chk("midrst dp_n", dp_n, 1'b1);
        chk("midrst ack", ack, 1'b0);
        chk("midrst frame", frame, 1'b0);
        rst = 1'b0;
        wait_frame(32, "post-rst");
        chk("post-rst ack", ack, 1'b0);
        chk("post-rst an", an, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
